execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 140 ++++++++++++++
 tb/tb_execute_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// MIPS EX stage: ALU, beq/bne/j resolution, PC redirect, EX/MEM register; optional wrong-path squash under EX_BRANCH_SQUASH_EN.
// Latency: 1 cycle from ID/EX inputs to XM_*/redirect outputs.
// Backpressure: none; one instruction accepted every cycle, never stalls.
module execute_stage #(
    parameter int SQUASH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        branch,
    input  logic        jump,
    input  logic [2:0]  ALUctr,
    input  logic [31:0] JT,
    input  logic [31:0] DX_PC,
    input  logic [31:0] NPC,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [15:0] imm,
    input  logic [4:0]  RD,
    input  logic [31:0] MD,
    output logic        XM_MemtoReg,
    output logic        XM_RegWrite,
    output logic        XM_MemRead,
    output logic        XM_MemWrite,
    output logic [31:0] XM_ALUout,
    output logic [31:0] XM_MD,
    output logic [4:0]  XM_RD,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [1:0]  squash_cnt
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_BEQ = 3'd5;
    localparam logic [2:0] OP_BNE = 3'd6;

    if (SQUASH_DEPTH < 1 || SQUASH_DEPTH > 3) begin : g_bad_depth
        $error("execute_stage: SQUASH_DEPTH must be 1..3");
    end

    logic [31:0] w_alu;
    logic        w_eq;
    logic        w_taken;
    logic        w_kill;
    logic [31:0] w_br_target;
    logic [31:0] w_target;
    logic [31:0] w_unused_pc;

    logic [3:0]  r_xm_ctl;
    logic [31:0] r_xm_alu;
    logic [31:0] r_xm_md;
    logic [4:0]  r_xm_rd;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;

    // DX_PC travels with the bundle but the EX stage never consumes it.
    assign w_unused_pc = DX_PC;

    always_comb begin
        w_alu = '0;
        case (ALUctr)
            OP_ADD:         w_alu = A + B;
            OP_SUB:         w_alu = A - B;
            OP_AND:         w_alu = A & B;
            OP_OR:          w_alu = A | B;
            OP_SLT:         w_alu = {31'd0, $signed(A) < $signed(B)};
            OP_BEQ, OP_BNE: w_alu = A - B;
            default:        w_alu = '0;
        endcase
    end

    assign w_eq        = (A == B);
    assign w_taken     = (branch & (ALUctr == OP_BEQ) & w_eq)
                       | (branch & (ALUctr == OP_BNE) & ~w_eq)
                       | jump;
    assign w_br_target = NPC + {{14{imm[15]}}, imm, 2'b00};
    assign w_target    = jump ? JT : w_br_target;

`ifdef EX_BRANCH_SQUASH_EN
    localparam logic [1:0] LP_DEPTH = 2'(SQUASH_DEPTH);

    logic [1:0] r_squash_cnt;

    // Any nonzero count means the incoming instruction is on the wrong path.
    assign w_kill = (r_squash_cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_squash_cnt <= 2'd0;
        end else if (w_kill) begin
            r_squash_cnt <= r_squash_cnt - 2'd1;
        end else if (w_taken) begin
            r_squash_cnt <= LP_DEPTH;
        end
    end

    assign squash_cnt = r_squash_cnt;
`else
    assign w_kill     = 1'b0;
    assign squash_cnt = 2'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xm_ctl      <= '0;
            r_xm_alu      <= '0;
            r_xm_md       <= '0;
            r_xm_rd       <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_xm_ctl   <= w_kill ? 4'd0 : {MemtoReg, RegWrite, MemRead, MemWrite};
            r_xm_alu   <= w_alu;
            r_xm_md    <= MD;
            r_xm_rd    <= RD;
            r_redirect <= w_taken & ~w_kill;
            if (w_taken && !w_kill) begin
                r_redirect_pc <= w_target;
            end
        end
    end

    assign XM_MemtoReg = r_xm_ctl[3];
    assign XM_RegWrite = r_xm_ctl[2];
    assign XM_MemRead  = r_xm_ctl[1];
    assign XM_MemWrite = r_xm_ctl[0];
    assign XM_ALUout   = r_xm_alu;
    assign XM_MD       = r_xm_md;
    assign XM_RD       = r_xm_rd;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_execute_stage.sv
// Directed + random bench for execute_stage; expectations are queued at issue and checked one cycle later.
module tb_execute_stage;

`ifdef EX_BRANCH_SQUASH_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemtoReg, RegWrite, MemRead, MemWrite;
    logic        branch, jump;
    logic [2:0]  ALUctr;
    logic [31:0] JT, DX_PC, NPC, A, B, MD;
    logic [15:0] imm;
    logic [4:0]  RD;
    logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
    logic [31:0] XM_ALUout, XM_MD;
    logic [4:0]  XM_RD;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  squash_cnt;

    execute_stage #(.SQUASH_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .branch(branch), .jump(jump), .ALUctr(ALUctr), .JT(JT), .DX_PC(DX_PC),
        .NPC(NPC), .A(A), .B(B), .imm(imm), .RD(RD), .MD(MD),
        .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
        .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
        .XM_ALUout(XM_ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD),
        .redirect(redirect), .redirect_pc(redirect_pc), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [31:0] alu;
        logic [31:0] md;
        logic [4:0]  rd;
        logic        redir;
        logic [31:0] rpc;
        logic [1:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [1:0]  m_cnt = 2'd0;
    logic [31:0] m_rpc = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("xm_ctl", {28'd0, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite}, {28'd0, e.ctl});
            chk("xm_alu", XM_ALUout, e.alu);
            chk("xm_md", XM_MD, e.md);
            chk("xm_rd", {27'd0, XM_RD}, {27'd0, e.rd});
            chk("redirect", {31'd0, redirect}, {31'd0, e.redir});
            chk("redirect_pc", redirect_pc, e.rpc);
            chk("squash_cnt", {30'd0, squash_cnt}, {30'd0, e.cnt});
        end
    endtask

    task automatic do_reset();
        exp_t e;
        rst = 1'b1;
        e = '0;
        m_cnt = 2'd0;
        m_rpc = 32'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pop_check();
    endtask

    // ctl = {MemtoReg, RegWrite, MemRead, MemWrite}
    task automatic issue(input logic [3:0] ctl, input logic br, input logic jmp, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                         input logic [31:0] npc, input logic [31:0] jt, input logic [4:0] rd);
        exp_t        e;
        logic        taken, kill;
        logic [31:0] tgt;
        {MemtoReg, RegWrite, MemRead, MemWrite} = ctl;
        branch = br; jump = jmp; ALUctr = op; A = a; B = b; imm = im;
        NPC = npc; JT = jt; RD = rd; DX_PC = npc - 32'd4; MD = $urandom;
        case (op)
            3'd0: e.alu = a + b;
            3'd1: e.alu = a - b;
            3'd2: e.alu = a & b;
            3'd3: e.alu = a | b;
            3'd4: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5, 3'd6: e.alu = a - b;
            default: e.alu = 32'd0;
        endcase
        taken = jmp || (br && op == 3'd5 && a == b) || (br && op == 3'd6 && a != b);
        kill  = SQ && (m_cnt != 2'd0);
        tgt   = jmp ? jt : npc + ({{16{im[15]}}, im} << 2);
        e.ctl   = kill ? 4'd0 : ctl;
        e.md    = MD;
        e.rd    = rd;
        e.redir = taken && !kill;
        if (e.redir) m_rpc = tgt;
        if (kill) m_cnt = m_cnt - 2'd1;
        else if (SQ && taken) m_cnt = 2'(DEPTH);
        e.rpc = m_rpc;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        rst = 1'b1;
        {MemtoReg, RegWrite, MemRead, MemWrite} = 4'd0;
        branch = 0; jump = 0; ALUctr = 0; JT = 0; DX_PC = 0; NPC = 0;
        A = 0; B = 0; imm = 0; RD = 0; MD = 0;
        do_reset();

        issue(4'b0100, 0, 0, 3'd0, 32'd5, 32'd3, 16'd0, 32'h40, 32'd0, 5'd9);
        chk("add_out", XM_ALUout, 32'd8);
        chk("add_rd", {27'd0, XM_RD}, 32'd9);
        chk("add_rw", {31'd0, XM_RegWrite}, 32'd1);
        issue(4'b0100, 0, 0, 3'd1, 32'd3, 32'd5, 16'd0, 32'h44, 32'd0, 5'd10);
        chk("sub_out", XM_ALUout, 32'hFFFF_FFFE);
        issue(4'b0100, 0, 0, 3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 16'd0, 32'h48, 32'd0, 5'd11);
        issue(4'b0100, 0, 0, 3'd3, 32'hF000_0001, 32'h0000_0F10, 16'd0, 32'h4C, 32'd0, 5'd12);
        issue(4'b0100, 0, 0, 3'd4, 32'hFFFF_FFFF, 32'd2, 16'd0, 32'h50, 32'd0, 5'd13);
        chk("slt_neg", XM_ALUout, 32'd1);
        issue(4'b0100, 0, 0, 3'd4, 32'd2, 32'hFFFF_FFFF, 16'd0, 32'h54, 32'd0, 5'd13);
        chk("slt_pos", XM_ALUout, 32'd0);
        issue(4'b1110, 0, 0, 3'd0, 32'h1000, 32'hFFFF_FFFC, 16'hFFFC, 32'h58, 32'd0, 5'd14);
        chk("lw_addr", XM_ALUout, 32'h0FFC);
        chk("lw_mr", {31'd0, XM_MemRead}, 32'd1);

        // beq taken, then three adds: first DEPTH are squashed only with the feature on
        issue(4'b0000, 1, 0, 3'd5, 32'd7, 32'd7, 16'h0003, 32'h100, 32'd0, 5'd0);
        chk("beq_redir", {31'd0, redirect}, 32'd1);
        chk("beq_pc", redirect_pc, 32'h10C);
        chk("beq_cnt", {30'd0, squash_cnt}, SQ ? 32'd2 : 32'd0);
        for (int i = 0; i < 3; i++) begin
            issue(4'b0100, 0, 0, 3'd0, 32'(i), 32'd1, 16'd0, 32'h104 + 32'(4 * i), 32'd0, 5'd3);
            chk("post_beq_rw", {31'd0, XM_RegWrite}, (SQ && i < 2) ? 32'd0 : 32'd1);
            chk("post_beq_redir", {31'd0, redirect}, 32'd0);
        end

        issue(4'b0000, 1, 0, 3'd6, 32'd4, 32'd4, 16'h0010, 32'h200, 32'd0, 5'd0);
        chk("bne_nt", {31'd0, redirect}, 32'd0);
        issue(4'b0000, 0, 1, 3'd7, 32'd9, 32'd1, 16'd0, 32'h204, 32'h0040_0020, 5'd0);
        chk("j_pc", redirect_pc, 32'h0040_0020);
        chk("j_alu", XM_ALUout, 32'd0);
        issue(4'b0100, 0, 0, 3'd0, 32'd1, 32'd1, 16'd0, 32'h208, 32'd0, 5'd4);
        issue(4'b0001, 0, 0, 3'd0, 32'd2, 32'd2, 16'd0, 32'h20C, 32'd0, 5'd5);

        // three back-to-back taken beqs, the last lands on the final kill cycle
        for (int i = 0; i < 3; i++) begin
            issue(4'b0000, 1, 0, 3'd5, 32'd1, 32'd1, 16'(i + 1), 32'h300 + 32'(4 * i), 32'd0, 5'd0);
            chk("b2b_redir", {31'd0, redirect}, (SQ && i > 0) ? 32'd0 : 32'd1);
        end
        issue(4'b0100, 0, 0, 3'd0, 32'd6, 32'd6, 16'd0, 32'h30C, 32'd0, 5'd6);
        chk("b2b_after_rw", {31'd0, XM_RegWrite}, 32'd1);

        // reset one cycle after a taken beq
        issue(4'b0000, 1, 0, 3'd5, 32'd2, 32'd2, 16'hFFFF, 32'h400, 32'd0, 5'd0);
        chk("pre_rst_pc", redirect_pc, 32'h3FC);
        RegWrite = 1'b1;
        do_reset();
        chk("rst_cnt", {30'd0, squash_cnt}, 32'd0);
        issue(4'b0100, 0, 0, 3'd0, 32'd10, 32'd20, 16'd0, 32'h8, 32'd0, 5'd7);
        chk("post_rst_rw", {31'd0, XM_RegWrite}, 32'd1);
        chk("post_rst_out", XM_ALUout, 32'd30);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 1) ? a : $urandom;
            issue(4'($urandom), (op == 3'd5 || op == 3'd6), (op == 3'd7), op, a, b,
                  16'($urandom), $urandom, $urandom, 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
